rx_auth: RTL and testbench

RX_AUTH -- requirements
Module: rx_auth

---
 rtl/rx_auth.sv | 164 ++++++++++++++++
 tb/tb_rx_auth.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_auth.sv
// rx_auth: UART receiver (8N1) feeding a command-driven power authorization FSM.
//
// The receiver decodes bytes from the asynchronous RX line. CMD_GO and CMD_STOP
// bytes, together with rider_off, step the authorization state. pwr_up enables
// the downstream balance, steering and PWM stages.
//
// Build option: define RX_FRAME_ERR_EN to reject frames whose stop bit samples
// low. A rejected frame pulses frm_err instead of rx_rdy. When the macro is not
// defined, the stop bit is ignored and frm_err is tied low.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous, active-high reset
//   RX         asynchronous UART serial input, idle high
//   rider_off  rider absent, synchronous to clk
//   rx_data    last accepted byte (first received bit is the LSB)
//   rx_rdy     one-cycle pulse when rx_data updates
//   frm_err    one-cycle pulse on a bad stop bit
//   pwr_up     registered power enable
//   auth_st    authorization state, for debug
//
// Authorization states:
//   state | meaning
//   OFF   | power disabled, waiting for CMD_GO
//   PWR1  | powered, normal operation
//   PWR2  | powered, stop requested; drops out as soon as the rider leaves
module rx_auth #(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] CMD_GO   = 8'h47,
    parameter logic [7:0] CMD_STOP = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up,
    output logic [1:0] auth_st
);

    localparam int            CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic [1:0] {
        AUTH_OFF  = 2'b00,
        AUTH_PWR1 = 2'b01,
        AUTH_PWR2 = 2'b10
    } auth_state_t;

    rx_state_t     rx_q, rx_nxt;
    auth_state_t   auth_q, auth_nxt;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          start_edge, baud_tick, last_bit, start_bad;

    // Two-flop synchronizer. rx_prev stores the previous synchronized value so
    // that a falling edge on the line can be detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign start_edge = rx_prev & ~rx_s2;
    // The down-counter reloads BAUD_DIV when it reaches the terminal count of 1.
    // This gives a sample spacing of exactly BAUD_DIV clocks.
    assign baud_tick  = (rx_q == RX_RECV) && (baud_cnt == CW'(1));
    assign last_bit   = (bit_cnt == 4'd9);
    assign start_bad  = (bit_cnt == 4'd0) && rx_s2;

    always_ff @(posedge clk) begin
        if (rst) rx_q <= RX_IDLE;
        else     rx_q <= rx_nxt;
    end

    always_comb begin
        rx_nxt = rx_q;
        case (rx_q)
            RX_IDLE: if (start_edge) rx_nxt = RX_RECV;
            RX_RECV: if (baud_tick && (start_bad || last_bit)) rx_nxt = RX_IDLE;
            default: rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            rx_data  <= 8'h00;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            if (rx_q == RX_IDLE) begin
                bit_cnt <= 4'd0;
                if (start_edge) baud_cnt <= BAUD_HALF;
            end else if (baud_tick) begin
                baud_cnt <= BAUD_FULL;
                bit_cnt  <= bit_cnt + 4'd1;
                if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
                    shreg <= {rx_s2, shreg[7:1]};
                if (last_bit) begin
`ifdef RX_FRAME_ERR_EN
                    if (!rx_s2) begin
                        frm_err <= 1'b1;
                    end else begin
                        rx_data <= shreg;
                        rx_rdy  <= 1'b1;
                    end
`else
                    rx_data <= shreg;
                    rx_rdy  <= 1'b1;
`endif
                end
            end else begin
                baud_cnt <= baud_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            auth_q <= AUTH_OFF;
            pwr_up <= 1'b0;
        end else begin
            auth_q <= auth_nxt;
            pwr_up <= (auth_nxt == AUTH_PWR1) || (auth_nxt == AUTH_PWR2);
        end
    end

    always_comb begin
        auth_nxt = auth_q;
        case (auth_q)
            AUTH_OFF:
                if (rx_rdy && rx_data == CMD_GO) auth_nxt = AUTH_PWR1;
            AUTH_PWR1:
                if (rx_rdy && rx_data == CMD_STOP)
                    auth_nxt = rider_off ? AUTH_OFF : AUTH_PWR2;
            AUTH_PWR2:
                // When GO and rider_off occur in the same cycle, GO wins.
                if (rx_rdy && rx_data == CMD_GO) auth_nxt = AUTH_PWR1;
                else if (rider_off)              auth_nxt = AUTH_OFF;
            default:
                auth_nxt = AUTH_OFF;
        endcase
    end

    assign auth_st = auth_q;

endmodule

// File: tb/tb_rx_auth.sv
// Testbench for rx_auth. It drives UART frames through a small BAUD_DIV and
// compares the results against a reference model of the authorization rules.
// The frame-error expectations follow RX_FRAME_ERR_EN.
module tb_rx_auth;

    localparam int BAUD = 32;
    localparam logic [7:0] GO   = 8'h47;
    localparam logic [7:0] STOP = 8'h53;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy, frm_err, pwr_up;
    logic [1:0] auth_st;

    int n_checks = 0;
    int n_fail   = 0;
    int frm_cnt  = 0;
    logic [7:0] rdy_q[$];

    rx_auth #(.BAUD_DIV(BAUD), .CMD_GO(GO), .CMD_STOP(STOP)) dut (
        .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err),
        .pwr_up(pwr_up), .auth_st(auth_st)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_rdy) rdy_q.push_back(rx_data);
        if (frm_err) frm_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic uart_tx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = fr[i];
            repeat (BAUD - 1) @(negedge clk);
        end
        if (!stop_bit) begin
            @(negedge clk);
            RX = 1'b1;
        end
    endtask

    task automatic wait_rdy(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 * BAUD; i++) begin
            @(negedge clk);
            if (rx_rdy) begin
                seen = 1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rdy_q.delete();
        frm_cnt = 0;
    endtask

    // Reference rules: 0=OFF, 1=PWR1, 2=PWR2
    function automatic int model_byte(input int st, input logic [7:0] b, input logic ro);
        if (st == 0) return (b == GO) ? 1 : 0;
        if (st == 1) begin
            if (b == STOP) return ro ? 0 : 2;
            return 1;
        end
        if (b == GO) return 1;
        return ro ? 0 : 2;
    endfunction

    int         st;
    logic [7:0] b;
    logic       ro;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_rdy", {31'd0, rx_rdy}, 0);
        check("rst_frm_err", {31'd0, frm_err}, 0);
        check("rst_pwr_up", {31'd0, pwr_up}, 0);
        check("rst_auth", {30'd0, auth_st}, 0);

        // A low glitch shorter than half a bit must be rejected.
        @(negedge clk);
        RX = 1'b0;
        repeat (13) @(negedge clk);
        RX = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        check("glitch_no_rdy", rdy_q.size(), 0);
        check("glitch_auth", {30'd0, auth_st}, 0);

        // Stop bit forced low.
        uart_tx(GO, 1'b0);
        repeat (4) @(negedge clk);
`ifdef RX_FRAME_ERR_EN
        check("ferr_pulse", frm_cnt, 1);
        check("ferr_no_rdy", rdy_q.size(), 0);
        check("ferr_pwr", {31'd0, pwr_up}, 0);
`else
        check("ferr_rdy", rdy_q.size(), 1);
        if (rdy_q.size() > 0) check("ferr_data", {24'd0, rdy_q[0]}, {24'd0, GO});
        check("ferr_pwr", {31'd0, pwr_up}, 1);
`endif
        do_reset();
        check("rst2_pwr", {31'd0, pwr_up}, 0);
        check("rst2_auth", {30'd0, auth_st}, 0);

        // Reset asserted during data bit 4 and held until the frame has passed.
        fork
            uart_tx(GO, 1'b1);
            begin
                repeat (5 * BAUD) @(negedge clk);
                rst = 1'b1;
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * BAUD) @(negedge clk);
        check("rstmid_no_rdy", rdy_q.size(), 0);
        check("rstmid_pwr", {31'd0, pwr_up}, 0);
        uart_tx(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        check("rstmid_next_cnt", rdy_q.size(), 1);
        if (rdy_q.size() > 0) check("rstmid_next_data", {24'd0, rdy_q[0]}, 32'h11);
        check("rstmid_next_auth", {30'd0, auth_st}, 0);
        rdy_q.delete();

        // GO: pwr_up rises one cycle after the rx_rdy pulse.
        fork
            uart_tx(GO, 1'b1);
            begin
                wait_rdy("go_rdy_seen");
                check("go_data", {24'd0, rx_data}, {24'd0, GO});
                check("go_pwr_same", {31'd0, pwr_up}, 0);
                @(negedge clk);
                check("go_pwr_next", {31'd0, pwr_up}, 1);
                check("go_auth", {30'd0, auth_st}, 1);
            end
        join

        // STOP with the rider present goes to PWR2; the rider leaving then drops power.
        uart_tx(STOP, 1'b1);
        repeat (2) @(negedge clk);
        check("stop_auth", {30'd0, auth_st}, 2);
        check("stop_pwr", {31'd0, pwr_up}, 1);
        rider_off = 1'b1;
        @(negedge clk);
        check("off_auth", {30'd0, auth_st}, 0);
        check("off_pwr", {31'd0, pwr_up}, 0);
        rider_off = 1'b0;

        // In PWR1, rider_off alone keeps power; STOP with the rider absent goes to OFF.
        uart_tx(GO, 1'b1);
        rider_off = 1'b1;
        repeat (5) @(negedge clk);
        check("pwr1_ro_auth", {30'd0, auth_st}, 1);
        check("pwr1_ro_pwr", {31'd0, pwr_up}, 1);
        uart_tx(STOP, 1'b1);
        repeat (2) @(negedge clk);
        check("stop_ro_auth", {30'd0, auth_st}, 0);
        check("stop_ro_pwr", {31'd0, pwr_up}, 0);
        rider_off = 1'b0;
        rdy_q.delete();

        // Two frames back-to-back with no idle bits between them.
        fork
            begin
                uart_tx(8'hA5, 1'b1);
                uart_tx(GO, 1'b1);
            end
            begin
                wait_rdy("b2b_first_seen");
                @(negedge clk);
                check("b2b_mid_auth", {30'd0, auth_st}, 0);
            end
        join
        repeat (2) @(negedge clk);
        check("b2b_cnt", rdy_q.size(), 2);
        if (rdy_q.size() == 2) begin
            check("b2b_d0", {24'd0, rdy_q[0]}, 32'hA5);
            check("b2b_d1", {24'd0, rdy_q[1]}, {24'd0, GO});
        end
        check("b2b_auth", {30'd0, auth_st}, 1);
        rdy_q.delete();

        // Random traffic, checked against the reference rules.
        st = 1;
        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       b = GO;
                1:       b = STOP;
                default: b = 8'($urandom);
            endcase
            @(negedge clk);
            rider_off = ro;
            if (st == 2 && ro) st = 0;
            uart_tx(b, 1'b1);
            st = model_byte(st, b, ro);
            repeat (2) @(negedge clk);
            check("rnd_cnt", rdy_q.size(), 1);
            if (rdy_q.size() > 0) check("rnd_data", {24'd0, rdy_q.pop_front()}, {24'd0, b});
            rdy_q.delete();
            check("rnd_auth", {30'd0, auth_st}, st);
            check("rnd_pwr", {31'd0, pwr_up}, (st != 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
